// File: rtl/prm_edge_pkg.sv
// rtl/prm_edge_pkg.sv - shared widths, state encoding and config packing for the PRM edge sweep
package prm_edge_pkg;

  localparam int JOINT_W    = 5;
  localparam int NUM_JOINTS = 3;
  localparam int CFG_W      = JOINT_W * NUM_JOINTS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [JOINT_W-1:0] j2;
    logic [JOINT_W-1:0] j1;
    logic [JOINT_W-1:0] j0;
  } cfg_t;

endpackage

// File: rtl/prm_joint_interp.sv
// rtl/prm_joint_interp.sv - per-joint linear interpolator with rounded fixed-point accumulator
module prm_joint_interp
  import prm_edge_pkg::*;
#(
  parameter int LOG2_STEPS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [JOINT_W-1:0] start_in,
  input  logic [JOINT_W-1:0] end_in,
  output logic [JOINT_W-1:0] sample
);

  localparam int ACC_W = JOINT_W + 1 + LOG2_STEPS;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (LOG2_STEPS - 1));

  logic [JOINT_W-1:0]      start_q;
  logic signed [JOINT_W:0] delta_q;
  logic signed [ACC_W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      delta_q <= '0;
      acc_q   <= '0;
    end else if (load) begin
      start_q <= start_in;
      delta_q <= $signed({1'b0, end_in}) - $signed({1'b0, start_in});
      acc_q   <= '0;
    end else if (step) begin
      acc_q <= acc_q + $signed({{LOG2_STEPS{delta_q[JOINT_W]}}, delta_q});
    end
  end

  // Result is always within 0..31, so the sum can be formed modulo 2^JOINT_W.
  assign sample = start_q + JOINT_W'((acc_q + HALF) >>> LOG2_STEPS);

endmodule

// File: rtl/prm_edge_sweep_seq.sv
// rtl/prm_edge_sweep_seq.sv - sequences interpolated edge samples into the obstacle checker
module prm_edge_sweep_seq
  import prm_edge_pkg::*;
#(
  parameter int LOG2_STEPS = 3,
  parameter int CHK_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CFG_W-1:0]      req_start,
  input  logic [CFG_W-1:0]      req_end,
  output logic [CFG_W-1:0]      chk_vec,
  input  logic                  chk_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_blocked,
  output logic [LOG2_STEPS:0]   rsp_idx
);

  localparam int K_W  = LOG2_STEPS + 1;
  localparam int P_N  = CHK_LAT + 1;
  localparam int TK_W = P_N * K_W;
  localparam logic [K_W-1:0] K_LAST  = K_W'(1 << LOG2_STEPS);
  localparam logic [P_N-1:0] TOP_BIT = P_N'(1) << CHK_LAT;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]         state;
  logic [K_W-1:0]     k_q;
  // Stage 0 is aligned with chk_vec; the result for a tag appears at stage CHK_LAT.
  logic [P_N-1:0]     tag_v;
  logic [TK_W-1:0]    tag_k;
  cfg_t               start_cfg, end_cfg;
  logic [JOINT_W-1:0] s0, s1, s2;
  logic               load, issue, hit_now, last_issue, pipe_clear;
  logic [K_W-1:0]     emerge_k;

  assign start_cfg = req_start;
  assign end_cfg   = req_end;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign load      = req_ready && req_valid;

  always_comb begin
    emerge_k   = tag_k[CHK_LAT*K_W +: K_W];
    hit_now    = tag_v[CHK_LAT] && chk_mask && !rsp_blocked;
    issue      = (state == ST_RUN) && !hit_now;
    last_issue = issue && (k_q == K_LAST);
    pipe_clear = ((tag_v & ~TOP_BIT) == '0);
  end

  prm_joint_interp #(.LOG2_STEPS(LOG2_STEPS)) u_j0 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(issue),
    .start_in(start_cfg.j0), .end_in(end_cfg.j0), .sample(s0)
  );
  prm_joint_interp #(.LOG2_STEPS(LOG2_STEPS)) u_j1 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(issue),
    .start_in(start_cfg.j1), .end_in(end_cfg.j1), .sample(s1)
  );
  prm_joint_interp #(.LOG2_STEPS(LOG2_STEPS)) u_j2 (
    .clk(clk), .rst_n(rst_n), .load(load), .step(issue),
    .start_in(start_cfg.j2), .end_in(end_cfg.j2), .sample(s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k_q         <= '0;
      tag_v       <= '0;
      tag_k       <= '0;
      chk_vec     <= '0;
      rsp_blocked <= 1'b0;
      rsp_idx     <= '0;
    end else begin
      tag_v <= (tag_v << 1) | P_N'(issue);
      tag_k <= (tag_k << K_W) | TK_W'(k_q);
      if (issue) begin
        chk_vec <= {s2, s1, s0};
        k_q     <= k_q + K_W'(1);
      end
      // Only the first returned hit is recorded; later hits are dropped.
      if (hit_now) begin
        rsp_blocked <= 1'b1;
        rsp_idx     <= emerge_k;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state <= ST_RUN;
            k_q   <= '0;
          end
        end
        ST_RUN: begin
          if (hit_now || last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_clear) state <= ST_DONE;
        end
        default: begin
          if (rsp_ready) begin
            state       <= ST_IDLE;
            rsp_blocked <= 1'b0;
            rsp_idx     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_sweep_seq.sv
// tb/tb_prm_edge_sweep_seq.sv - directed bench with table checker and delay-line model
module tb_prm_edge_sweep_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        rsp_ready = 1'b0, rsp_ready0 = 1'b0;
  logic [14:0] req_start = '0, req_end = '0;
  logic        req_ready, req_ready0, rsp_valid, rsp_valid0;
  logic        rsp_blocked, rsp_blocked0, chk_mask;
  logic [14:0] chk_vec, chk_vec0;
  logic [3:0]  rsp_idx, rsp_idx0;

  logic        blk_en = 1'b0;
  logic [14:0] blk_code = '0;
  logic [LAT-1:0] dly;

  int n_chk = 0;
  int n_bad = 0;
  int lat;
  int seen;
  logic [14:0] vlog [40];
  int up_tab [9] = '{0, 4, 8, 12, 16, 19, 23, 27, 31};
  int dn_tab [9] = '{31, 27, 23, 19, 16, 12, 8, 4, 0};

  always #5 clk = ~clk;

  prm_edge_sweep_seq #(.LOG2_STEPS(3), .CHK_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_end(req_end), .chk_vec(chk_vec), .chk_mask(chk_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_blocked(rsp_blocked), .rsp_idx(rsp_idx)
  );

  prm_edge_sweep_seq #(.LOG2_STEPS(3), .CHK_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_start(req_start), .req_end(req_end), .chk_vec(chk_vec0), .chk_mask(1'b0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_blocked(rsp_blocked0), .rsp_idx(rsp_idx0)
  );

  // Checker model: blocked-code table lookup followed by a LAT-cycle delay line.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= '0;
    else        dly <= {dly[LAT-2:0], blk_en && (chk_vec == blk_code)};
  end
  assign chk_mask = dly[LAT-1];

  function automatic logic [14:0] rep3(input int v);
    logic [4:0] j;
    j = v[4:0];
    return {j, j, j};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input bit sel, input logic [14:0] s, input logic [14:0] e);
    @(negedge clk);
    req_start = s;
    req_end   = e;
    if (sel) req_valid0 = 1'b1;
    else     req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
  endtask

  task automatic wait_rsp(input bit sel, output int l);
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      vlog[n-1] = sel ? chk_vec0 : chk_vec;
      if (sel ? rsp_valid0 : rsp_valid) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic accept(input bit sel);
    if (sel) rsp_ready0 = 1'b1;
    else     rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
    rsp_ready0 = 1'b0;
    chk("acc_valid", sel ? rsp_valid0 : rsp_valid, 0);
    chk("acc_ready", sel ? req_ready0 : req_ready, 1);
    chk("acc_blk",   sel ? rsp_blocked0 : rsp_blocked, 0);
    chk("acc_idx",   sel ? rsp_idx0 : rsp_idx, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_vec",   chk_vec, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_blk",   rsp_blocked, 0);
    chk("rst_idx",   rsp_idx, 0);
    rst_n = 1'b1;

    // Free ramp on the zero-latency checker: 9 vectors, verdict 10 cycles after accept
    send_req(1'b1, 15'h0000, 15'h7FFF);
    wait_rsp(1'b1, lat);
    chk("t1_lat", lat, 10);
    for (int j = 0; j < 9; j++) chk($sformatf("t1_vec%0d", j), vlog[j], rep3(up_tab[j]));
    chk("t1_blk", rsp_blocked0, 0);
    chk("t1_idx", rsp_idx0, 0);
    accept(1'b1);

    // Same edge, two-cycle checker
    send_req(1'b0, 15'h0000, 15'h7FFF);
    wait_rsp(1'b0, lat);
    chk("t1l_lat", lat, 12);
    chk("t1l_last", vlog[8], 15'h7FFF);
    chk("t1l_blk", rsp_blocked, 0);
    accept(1'b0);

    // Sample 4 blocked: issuing stops after k=6, verdict after drain
    blk_en = 1'b1; blk_code = rep3(16);
    send_req(1'b0, 15'h0000, 15'h7FFF);
    wait_rsp(1'b0, lat);
    chk("t2_lat", lat, 10);
    for (int j = 0; j < 7; j++) chk($sformatf("t2_vec%0d", j), vlog[j], rep3(up_tab[j]));
    chk("t2_stop", vlog[7], rep3(up_tab[6]));
    chk("t2_blk", rsp_blocked, 1);
    chk("t2_idx", rsp_idx, 4);
    blk_en = 1'b0;

    // Verdict held while consumer stalls; a request in DONE is ignored
    req_start = 15'h001F; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_valid", rsp_valid, 1);
      chk("t6_blk",   rsp_blocked, 1);
      chk("t6_idx",   rsp_idx, 4);
      chk("t6_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    accept(1'b0);

    // start == end: full sweep of identical vectors, then sample 0 blocked
    send_req(1'b0, 15'h1234, 15'h1234);
    wait_rsp(1'b0, lat);
    chk("t3_lat", lat, 12);
    for (int j = 0; j < 9; j++) chk($sformatf("t3_vec%0d", j), vlog[j], 15'h1234);
    chk("t3_blk", rsp_blocked, 0);
    accept(1'b0);
    blk_en = 1'b1; blk_code = 15'h1234;
    send_req(1'b0, 15'h1234, 15'h1234);
    wait_rsp(1'b0, lat);
    chk("t3b_lat", lat, 6);
    chk("t3b_vec", vlog[5], 15'h1234);
    chk("t3b_blk", rsp_blocked, 1);
    chk("t3b_idx", rsp_idx, 0);
    blk_en = 1'b0;
    accept(1'b0);

    // Descending j0 with the final sample blocked; rsp_ready held high throughout
    blk_en = 1'b1; blk_code = 15'h0000;
    rsp_ready = 1'b1;
    send_req(1'b0, 15'h001F, 15'h0000);
    wait_rsp(1'b0, lat);
    chk("t4_lat", lat, 12);
    for (int j = 0; j < 9; j++) chk($sformatf("t4_vec%0d", j), vlog[j], 15'(dn_tab[j]));
    chk("t4_blk", rsp_blocked, 1);
    chk("t4_idx", rsp_idx, 8);
    blk_en = 1'b0;
    accept(1'b0);

    // Reset mid-RUN aborts silently, next edge runs normally
    send_req(1'b0, 15'h0000, 15'h7FFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_vec",   chk_vec, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_blk",   rsp_blocked, 0);
    chk("t5_idx",   rsp_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("t5_norsp", seen, 0);
    send_req(1'b0, 15'h0000, 15'h7FFF);
    wait_rsp(1'b0, lat);
    chk("t5r_lat", lat, 12);
    chk("t5r_last", vlog[8], 15'h7FFF);
    chk("t5r_blk", rsp_blocked, 0);
    accept(1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
